// File: rtl/oled_spi_tx.sv
// oled_spi_tx: queues {dc, byte} writes from the CPU OLED register and shifts
// them MSB-first to the SPI OLED panel (SCLK idles high, sampled on its rise).
module oled_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clkX4,
  input  logic       rst,
  input  logic       wrValid,
  input  logic [7:0] wrData,
  input  logic       wrDC,
  output logic       wrReady,
  output logic       busy,
  output logic       SDIN,
  output logic       SCLK,
  output logic       DC,
  output logic       CS_N
);

  // state | meaning
  // IDLE  | CS_N high, waiting for a queued byte
  // LOW   | SCLK low, SDIN/DC settled ahead of the next rise
  // HIGH  | SCLK high, panel has sampled SDIN
  // GAP   | CS_N high hold-off after a burst ends

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_t;

  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             div_done;
  logic             head_dc;
  logic [7:0]       head_byte;

  assign fifo_empty = (count == '0);
  assign wrReady    = (count != CNT_FULL);
  assign push       = wrValid && wrReady;
  assign div_done   = (div_cnt == DIV_LAST);
  assign busy       = !fifo_empty || (state != IDLE);
  assign {head_dc, head_byte} = mem[rd_ptr];

  // A byte is popped from IDLE, or at the end of the last HIGH phase so that
  // back-to-back bytes share one CS_N window.
  assign pop = !fifo_empty &&
               ((state == IDLE) ||
                ((state == HIGH) && div_done && (bit_cnt == 3'd0)));

  always_ff @(posedge clkX4) begin
    if (push) begin
      mem[wr_ptr] <= {wrDC, wrData};
    end
  end

  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      SCLK    <= 1'b1;
      CS_N    <= 1'b1;
      SDIN    <= 1'b0;
      DC      <= 1'b0;
    end else if (pop) begin
      shreg   <= {head_byte[6:0], 1'b0};
      SDIN    <= head_byte[7];
      DC      <= head_dc;
      CS_N    <= 1'b0;
      SCLK    <= 1'b0;
      bit_cnt <= 3'd7;
      div_cnt <= '0;
      state   <= LOW;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
        end
        LOW: begin
          if (div_done) begin
            SCLK    <= 1'b1;
            div_cnt <= '0;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (div_done) begin
            div_cnt <= '0;
            if (bit_cnt != 3'd0) begin
              SCLK    <= 1'b0;
              SDIN    <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt - 3'd1;
              state   <= LOW;
            end else begin
              CS_N  <= 1'b1;
              state <= GAP;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (div_done) begin
            div_cnt <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          div_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_tx.sv
// tb_oled_spi_tx: drives two instances (CLK_DIV=4 and CLK_DIV=1) with directed
// byte streams and checks them against a timeline model and decoded SPI bytes.
module tb_oled_spi_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] vld = 2'b00;
  logic [7:0] dat [2];
  logic [1:0] dcin = 2'b00;
  logic [1:0] rdy, bsy, sdin, sclk, dco, csn;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  oled_spi_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) u_div4 (
    .clkX4(clk), .rst(rst), .wrValid(vld[0]), .wrData(dat[0]), .wrDC(dcin[0]),
    .wrReady(rdy[0]), .busy(bsy[0]), .SDIN(sdin[0]), .SCLK(sclk[0]),
    .DC(dco[0]), .CS_N(csn[0]));

  oled_spi_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) u_div1 (
    .clkX4(clk), .rst(rst), .wrValid(vld[1]), .wrData(dat[1]), .wrDC(dcin[1]),
    .wrReady(rdy[1]), .busy(bsy[1]), .SDIN(sdin[1]), .SCLK(sclk[1]),
    .DC(dco[1]), .CS_N(csn[1]));

  task automatic chk(input string nm, input int id, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, id, act, exp);
    end
  endtask

  // Model: a queue of accepted entries plus a per-byte cycle index t; the wire
  // waveform inside a byte follows directly from t and CLK_DIV.
  logic [8:0] mf  [2][4];
  int         m_hd [2] = '{0, 0};
  int         m_sz [2] = '{0, 0};
  int         m_active [2] = '{0, 0};
  int         m_t  [2] = '{0, 0};
  int         m_gap [2] = '{0, 0};
  logic [8:0] m_cur [2];
  logic [8:0] acc [2][64];
  int         acc_n [2] = '{0, 0};
  int         clr_gen = 0;
  int         clr_seen_m = 0;
  int         clr_seen_d = 0;

  function automatic int dv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic model_pop(input int i);
    m_cur[i] = mf[i][m_hd[i]];
    m_hd[i]  = (m_hd[i] + 1) % 4;
    m_sz[i]  = m_sz[i] - 1;
  endtask

  task automatic model_step(input int i);
    bit         accept;
    logic [8:0] entry;
    int         d;
    d      = dv(i);
    accept = vld[i] && (m_sz[i] < 4);
    entry  = {dcin[i], dat[i]};
    if (m_active[i] != 0) begin
      m_t[i] = m_t[i] + 1;
      if (m_t[i] == 16 * d) begin
        if (m_sz[i] > 0) begin
          model_pop(i);
          m_t[i] = 0;
        end else begin
          m_active[i] = 0;
          m_gap[i]    = d;
        end
      end
    end else if (m_gap[i] > 0) begin
      m_gap[i] = m_gap[i] - 1;
    end else if (m_sz[i] > 0) begin
      model_pop(i);
      m_active[i] = 1;
      m_t[i]      = 0;
    end
    if (accept) begin
      mf[i][(m_hd[i] + m_sz[i]) % 4] = entry;
      m_sz[i] = m_sz[i] + 1;
      if (acc_n[i] < 64) acc[i][acc_n[i]] = entry;
      acc_n[i] = acc_n[i] + 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 0; m_gap[i] = 0; m_sz[i] = 0; m_hd[i] = 0; m_t[i] = 0;
      end
    end else begin
      if (clr_seen_m != clr_gen) begin
        acc_n[0] = 0; acc_n[1] = 0;
        clr_seen_m = clr_gen;
      end
      model_step(0);
      model_step(1);
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int d;
      d = dv(i);
      chk("sclk",  i, sclk[i], (m_active[i] != 0) ? ((m_t[i] / d) % 2) : 1);
      chk("cs_n",  i, csn[i],  (m_active[i] != 0) ? 0 : 1);
      chk("ready", i, rdy[i],  (m_sz[i] < 4) ? 1 : 0);
      chk("busy",  i, bsy[i],
          ((m_active[i] != 0) || (m_gap[i] > 0) || (m_sz[i] > 0)) ? 1 : 0);
      if (m_active[i] != 0) begin
        chk("sdin", i, sdin[i], m_cur[i][7 - m_t[i] / (2 * d)]);
        chk("dc",   i, dco[i],  m_cur[i][8]);
      end
    end
  end

  // Wire-level decoder: reconstructs bytes from SDIN at each SCLK rise.
  logic [8:0] dec [2][64];
  int         dec_n [2] = '{0, 0};
  int         rises [2] = '{0, 0};
  int         csn_low [2] = '{0, 0};
  int         csn_rises [2] = '{0, 0};
  int         first_rise [2] = '{-1, -1};
  int         dbits [2] = '{0, 0};
  logic [7:0] dsh [2];
  logic [1:0] prev_sclk = 2'b11;
  logic [1:0] prev_csn  = 2'b11;

  initial forever begin
    @(negedge clk);
    if (clr_seen_d != clr_gen) begin
      for (int i = 0; i < 2; i++) begin
        dec_n[i] = 0; rises[i] = 0; csn_low[i] = 0; csn_rises[i] = 0;
        first_rise[i] = -1; dbits[i] = 0;
      end
      clr_seen_d = clr_gen;
    end
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        dbits[i] = 0;
        prev_sclk[i] = 1'b1;
        prev_csn[i]  = 1'b1;
      end else begin
        if (!prev_sclk[i] && sclk[i]) begin
          if (rises[i] == 0) first_rise[i] = cyc;
          rises[i] = rises[i] + 1;
          dsh[i]   = {dsh[i][6:0], sdin[i]};
          dbits[i] = dbits[i] + 1;
          if (dbits[i] == 8) begin
            if (dec_n[i] < 64) dec[i][dec_n[i]] = {dco[i], dsh[i]};
            dec_n[i] = dec_n[i] + 1;
            dbits[i] = 0;
          end
        end
        if (!csn[i]) csn_low[i] = csn_low[i] + 1;
        if (!prev_csn[i] && csn[i]) csn_rises[i] = csn_rises[i] + 1;
        prev_sclk[i] = sclk[i];
        prev_csn[i]  = csn[i];
      end
    end
  end

  int push_cyc [2] = '{0, 0};

  task automatic offer(input int i, input logic [7:0] b, input logic dc);
    vld[i]  = 1'b1;
    dat[i]  = b;
    dcin[i] = dc;
    @(negedge clk);
    push_cyc[i] = cyc;
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 3000; k++) begin
      if (!bsy[i]) break;
      @(negedge clk);
    end
    chk("idle_timeout", i, bsy[i], 0);
  endtask

  task automatic clr_stats();
    clr_gen = clr_gen + 1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_acc(input int i);
    chk("acc_count", i, dec_n[i], acc_n[i]);
    for (int k = 0; k < acc_n[i] && k < 64; k++) begin
      chk("acc_byte", i, dec[i][k], acc[i][k]);
    end
  endtask

  task automatic check_reset_pins();
    for (int i = 0; i < 2; i++) begin
      chk("rst_sclk",  i, sclk[i], 1);
      chk("rst_cs_n",  i, csn[i],  1);
      chk("rst_sdin",  i, sdin[i], 0);
      chk("rst_dc",    i, dco[i],  0);
      chk("rst_ready", i, rdy[i],  1);
      chk("rst_busy",  i, bsy[i],  0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_pins();
    rst = 1'b1;
    @(negedge clk);

    // 0xA5 as display data at CLK_DIV=4
    clr_stats();
    offer(0, 8'hA5, 1'b1);
    vld[0] = 1'b0;
    wait_idle(0);
    chk("s2_nbytes",  0, dec_n[0], 1);
    chk("s2_byte",    0, dec[0][0], 9'h1A5);
    chk("s2_rises",   0, rises[0], 8);
    chk("s2_csn_low", 0, csn_low[0], 64);
    chk("s2_latency", 0, first_rise[0] - push_cyc[0], 5);

    // three back-to-back bytes share one CS_N window
    clr_stats();
    offer(0, 8'h01, 1'b0);
    offer(0, 8'h02, 1'b0);
    offer(0, 8'hFF, 1'b1);
    vld[0] = 1'b0;
    wait_idle(0);
    chk("s3_rises",     0, rises[0], 24);
    chk("s3_csn_low",   0, csn_low[0], 192);
    chk("s3_csn_rises", 0, csn_rises[0], 1);
    chk("s3_nbytes",    0, dec_n[0], 3);
    chk("s3_byte0",     0, dec[0][0], 9'h001);
    chk("s3_byte1",     0, dec[0][1], 9'h002);
    chk("s3_byte2",     0, dec[0][2], 9'h1FF);
    check_acc(0);

    // overfill the FIFO while a byte is shifting
    clr_stats();
    offer(0, 8'h11, 1'b0);
    vld[0] = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      vld[0]  = 1'b1;
      dat[0]  = 8'h20 + 8'(k);
      dcin[0] = k[0];
      chk("s4_ready", 0, rdy[0], (k < 4) ? 1 : 0);
      @(negedge clk);
    end
    vld[0] = 1'b0;
    wait_idle(0);
    chk("s4_nbytes", 0, dec_n[0], 5);
    chk("s4_byte0",  0, dec[0][0], 9'h011);
    chk("s4_byte1",  0, dec[0][1], 9'h020);
    chk("s4_byte2",  0, dec[0][2], 9'h121);
    chk("s4_byte3",  0, dec[0][3], 9'h022);
    chk("s4_byte4",  0, dec[0][4], 9'h123);

    // reset mid-byte with two bytes queued
    clr_stats();
    offer(0, 8'h3C, 1'b1);
    offer(0, 8'h55, 1'b0);
    offer(0, 8'h66, 1'b1);
    vld[0] = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (rises[0] >= 3) break;
      @(negedge clk);
    end
    chk("s5_third_rise", 0, (rises[0] >= 3) ? 1 : 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_pins();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clr_stats();
    repeat (10) @(negedge clk);
    chk("s5_flushed", 0, dec_n[0], 0);
    chk("s5_idle",    0, bsy[0], 0);
    offer(0, 8'h81, 1'b0);
    vld[0] = 1'b0;
    wait_idle(0);
    chk("s5_nbytes", 0, dec_n[0], 1);
    chk("s5_byte",   0, dec[0][0], 9'h081);
    chk("s5_rises",  0, rises[0], 8);

    // CLK_DIV=1 instance
    clr_stats();
    offer(1, 8'hA5, 1'b1);
    vld[1] = 1'b0;
    wait_idle(1);
    chk("s6_nbytes",  1, dec_n[1], 1);
    chk("s6_byte",    1, dec[1][0], 9'h1A5);
    chk("s6_rises",   1, rises[1], 8);
    chk("s6_csn_low", 1, csn_low[1], 16);
    chk("s6_latency", 1, first_rise[1] - push_cyc[1], 2);

    clr_stats();
    for (int k = 0; k < 24; k++) begin
      offer(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      vld[1] = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(1);
    check_acc(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
